// File: rtl/csa_accum.sv
// Carry-save group accumulator: operands are folded in redundant (sum, carry) form
// at one per cycle, and a single carry-propagate add resolves the group.
module csa_accum #(
  parameter  int WIDTH   = 8,
  parameter  int MAX_OPS = 16,
  localparam int OUT_W   = WIDTH + $clog2(MAX_OPS),
  localparam int CNT_W   = $clog2(MAX_OPS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  if (WIDTH < 2 || MAX_OPS < 2) begin : g_param_check
    $error("csa_accum: WIDTH and MAX_OPS must both be at least 2");
  end

  typedef enum logic [1:0] {
    S_ACCUM   = 2'd0,
    S_RESOLVE = 2'd1,
    S_OUTPUT  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [OUT_W-1:0]   sum_q, sum_d;
  logic [OUT_W-1:0]   carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [OUT_W-1:0]   result_q, result_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               rdy_q;

  logic [OUT_W-1:0]   d_ext;
  logic [OUT_W-1:0]   csa_sum;
  logic [OUT_W-1:0]   csa_maj;
  logic [CNT_W-1:0]   cnt_inc;
  logic               in_fire;
  logic               out_fire;

  // rdy_q keeps in_ready low through reset and the edge that releases it.
  assign in_ready  = rdy_q && (state_q == S_ACCUM);
  assign out_valid = (state_q == S_OUTPUT);
  assign out_sum   = result_q;
  assign out_count = count_q;
  assign out_ovf   = ovf_q;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  assign d_ext   = {{(OUT_W - WIDTH){1'b0}}, in_data};
  assign csa_sum = sum_q ^ carry_q ^ d_ext;
  assign csa_maj = (sum_q & carry_q) | (sum_q & d_ext) | (carry_q & d_ext);
  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d  = state_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      S_ACCUM: begin
        if (in_fire) begin
          sum_d   = csa_sum;
          carry_d = {csa_maj[OUT_W-2:0], 1'b0};
          cnt_d   = cnt_inc;
          if (in_last) begin
            state_d = S_RESOLVE;
            ovf_d   = 1'b0;
          end else if (cnt_inc == CNT_W'(MAX_OPS)) begin
            state_d = S_RESOLVE;
            ovf_d   = 1'b1;
          end
        end
      end
      S_RESOLVE: begin
        // The only carry-propagate add, once per group.
        result_d = sum_q + carry_q;
        count_d  = cnt_q;
        state_d  = S_OUTPUT;
      end
      S_OUTPUT: begin
        if (out_fire) begin
          sum_d   = '0;
          carry_d = '0;
          cnt_d   = '0;
          state_d = S_ACCUM;
        end
      end
      default: begin
        state_d = S_ACCUM;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_ACCUM;
      sum_q    <= '0;
      carry_q  <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      rdy_q    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_csa_accum.sv
// Bench for csa_accum: directed vector table, hand-written corner sequences and
// random groups checked against a plain-arithmetic group-sum model.
module tb_csa_accum;

  logic        clk = 1'b0;
  logic        rst_n;

  // Instance A: WIDTH=8, MAX_OPS=16 (OUT_W=12, CNT_W=5)
  logic        in_valid, in_ready, in_last, out_valid, out_ready, out_ovf;
  logic [7:0]  in_data;
  logic [11:0] out_sum;
  logic [4:0]  out_count;

  // Instance B: WIDTH=16, MAX_OPS=4 (OUT_W=18, CNT_W=3)
  logic        b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready, b_out_ovf;
  logic [15:0] b_in_data;
  logic [17:0] b_out_sum;
  logic [2:0]  b_out_count;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  csa_accum #(.WIDTH(8), .MAX_OPS(16)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_count(out_count), .out_ovf(out_ovf)
  );

  csa_accum #(.WIDTH(16), .MAX_OPS(4)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_last(b_in_last),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_sum(b_out_sum), .out_count(b_out_count), .out_ovf(b_out_ovf)
  );

  typedef struct {
    int         n;
    logic [7:0] ops[16];
    bit         last;
    int         esum;
    int         ecnt;
    bit         eovf;
    int         stall;
  } vec_t;

  vec_t vt[7];

  task automatic chk(input string nm, input longint act, input longint exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // Called just after a falling edge; the operand is sampled on the next rising edge.
  task automatic send(input logic [7:0] d, input bit last);
    chk("in_ready_accum", in_ready, 1);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic expect_result(input int es, input int ec, input bit eo, input int stall);
    int t;
    chk("valid_in_resolve", out_valid, 0);
    chk("ready_in_resolve", in_ready, 0);
    @(negedge clk);
    t = 0;
    while (!out_valid && t < 8) begin
      @(negedge clk);
      t++;
    end
    chk("latency_extra_cycles", t, 0);
    chk("out_sum", out_sum, es);
    chk("out_count", out_count, ec);
    chk("out_ovf", out_ovf, eo);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("stall_valid", out_valid, 1);
      chk("stall_sum", out_sum, es);
      chk("stall_count", out_count, ec);
      chk("stall_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("valid_after_hs", out_valid, 0);
    chk("ready_after_hs", in_ready, 1);
  endtask

  task automatic b_send(input logic [15:0] d, input bit last);
    chk("b_in_ready", b_in_ready, 1);
    b_in_valid = 1'b1;
    b_in_data  = d;
    b_in_last  = last;
    @(negedge clk);
    b_in_valid = 1'b0;
    b_in_last  = 1'b0;
  endtask

  task automatic b_expect(input int es, input int ec, input bit eo);
    chk("b_valid_resolve", b_out_valid, 0);
    @(negedge clk);
    chk("b_out_valid", b_out_valid, 1);
    chk("b_out_sum", b_out_sum, es);
    chk("b_out_count", b_out_count, ec);
    chk("b_out_ovf", b_out_ovf, eo);
    b_out_ready = 1'b1;
    @(negedge clk);
    b_out_ready = 1'b0;
    chk("b_valid_after_hs", b_out_valid, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 0; in_last = 0; in_data = '0; out_ready = 0;
    b_in_valid = 0; b_in_last = 0; b_in_data = '0; b_out_ready = 0;

    // Vector table: hand-computed group sums.
    vt[0].n = 3;  vt[0].ops[0] = 8'hA3; vt[0].ops[1] = 8'hD2; vt[0].ops[2] = 8'hDD;
    vt[0].last = 1; vt[0].esum = 594;  vt[0].ecnt = 3;  vt[0].eovf = 0; vt[0].stall = 0;
    vt[1].n = 16; for (int i = 0; i < 16; i++) vt[1].ops[i] = 8'hFF;
    vt[1].last = 0; vt[1].esum = 4080; vt[1].ecnt = 16; vt[1].eovf = 1; vt[1].stall = 1;
    vt[2].n = 1;  vt[2].ops[0] = 8'h00;
    vt[2].last = 1; vt[2].esum = 0;    vt[2].ecnt = 1;  vt[2].eovf = 0; vt[2].stall = 5;
    vt[3].n = 2;  vt[3].ops[0] = 8'hFF; vt[3].ops[1] = 8'h01;
    vt[3].last = 1; vt[3].esum = 256;  vt[3].ecnt = 2;  vt[3].eovf = 0; vt[3].stall = 2;
    vt[4].n = 15; for (int i = 0; i < 16; i++) vt[4].ops[i] = 8'h80;
    vt[4].last = 1; vt[4].esum = 1920; vt[4].ecnt = 15; vt[4].eovf = 0; vt[4].stall = 0;
    vt[5].n = 16; for (int i = 0; i < 16; i++) vt[5].ops[i] = 8'h01;
    vt[5].last = 1; vt[5].esum = 16;   vt[5].ecnt = 16; vt[5].eovf = 0; vt[5].stall = 0;
    vt[6].n = 16; for (int i = 0; i < 16; i++) vt[6].ops[i] = 8'h00;
    vt[6].last = 0; vt[6].esum = 0;    vt[6].ecnt = 16; vt[6].eovf = 1; vt[6].stall = 3;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_out_ovf", out_ovf, 0);
    rst_n = 1'b1;
    #1;
    chk("ready_before_first_edge", in_ready, 0);
    @(negedge clk);
    chk("ready_after_first_edge", in_ready, 1);
    chk("b_ready_after_first_edge", b_in_ready, 1);

    // Table-driven groups
    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < vt[v].n; i++)
        send(vt[v].ops[i], vt[v].last && (i == vt[v].n - 1));
      expect_result(vt[v].esum, vt[v].ecnt, vt[v].eovf, vt[v].stall);
    end

    // Overflow close with a 17th operand held pending through RESOLVE/OUTPUT
    for (int i = 0; i < 16; i++) send(8'hFF, 1'b0);
    in_valid = 1'b1; in_data = 8'h11; in_last = 1'b1;
    chk("ovf_stall_ready", in_ready, 0);
    chk("ovf_valid_resolve", out_valid, 0);
    @(negedge clk);
    chk("ovf_stall_ready2", in_ready, 0);
    chk("ovf_valid", out_valid, 1);
    chk("ovf_sum", out_sum, 4080);
    chk("ovf_count", out_count, 16);
    chk("ovf_flag", out_ovf, 1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("ovf_after_hs_valid", out_valid, 0);
    chk("ovf_after_hs_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
    expect_result(17, 1, 0, 0);

    // Reset mid-group discards the partial group; stray in_last without valid is ignored
    send(8'h40, 1'b0);
    send(8'h41, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", in_ready, 0);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_sum", out_sum, 0);
    @(negedge clk);
    rst_n = 1'b1;
    in_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("postrst_no_valid", out_valid, 0);
    end
    in_last = 1'b0;
    send(8'h05, 1'b1);
    expect_result(5, 1, 0, 0);

    // Two back-to-back groups with out_ready tied high
    out_ready = 1'b1;
    send(8'h01, 1'b0);
    send(8'h02, 1'b1);
    in_valid = 1'b1; in_data = 8'h03; in_last = 1'b1;
    chk("b2b_valid_resolve", out_valid, 0);
    @(negedge clk);
    chk("b2b_g1_valid", out_valid, 1);
    chk("b2b_g1_sum", out_sum, 3);
    chk("b2b_g1_count", out_count, 2);
    @(negedge clk);
    chk("b2b_hs_valid", out_valid, 0);
    chk("b2b_hs_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    chk("b2b_g2_resolve", out_valid, 0);
    @(negedge clk);
    chk("b2b_g2_valid", out_valid, 1);
    chk("b2b_g2_sum", out_sum, 3);
    chk("b2b_g2_count", out_count, 1);
    @(negedge clk);
    out_ready = 1'b0;
    chk("b2b_g2_done", out_valid, 0);

    // Instance B: wider operands, small MAX_OPS
    b_send(16'd4231, 1'b0);
    b_send(16'd7642, 1'b0);
    b_send(16'd3254, 1'b1);
    b_expect(15127, 3, 0);
    for (int i = 0; i < 4; i++) b_send(16'hFFFF, 1'b0);
    b_expect(262140, 4, 1);

    // Random groups against a plain-sum reference
    for (int g = 0; g < 40; g++) begin
      int n, ref_sum, stall;
      bit last;
      logic [7:0] op;
      n = int'($urandom_range(1, 16));
      last = (n < 16) ? 1'b1 : bit'($urandom_range(0, 1));
      stall = int'($urandom_range(0, 3));
      ref_sum = 0;
      for (int i = 0; i < n; i++) begin
        int bub;
        bub = int'($urandom_range(0, 2));
        for (int k = 0; k < bub; k++) @(negedge clk);
        op = 8'($urandom);
        ref_sum += int'(op);
        send(op, last && (i == n - 1));
      end
      expect_result(ref_sum, n, (n == 16) && !last, stall);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
